// File: rtl/ps2_receiver_if.sv
// Scan-code output bundle from the PS/2 receiver to the ASCII translation stage.
// now_data   : last good scan code, held until the next good frame
// ready      : one-cycle strobe, now_data is new in this cycle
// parity_err : one-cycle strobe, frame dropped for bad odd parity
// frame_err  : one-cycle strobe, frame dropped for stop bit 0 or timeout
interface ps2_receiver_if;
  logic [7:0] now_data;
  logic       ready;
  logic       parity_err;
  logic       frame_err;

  modport master (output now_data, ready, parity_err, frame_err);
  modport slave  (input  now_data, ready, parity_err, frame_err);
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw PS/2
// clock, deserializes 11-bit frames (start, 8 data LSB first, odd parity,
// stop) and forwards good scan codes; bad or stalled frames are flagged.
// Ports:
//   CLK_50   : system clock (only clock)
//   RST_N    : asynchronous active-low reset
//   PS2_CLK  : raw PS/2 clock pin (asynchronous)
//   PS2_DATA : raw PS/2 data pin (asynchronous)
//   out_if   : registered scan code and status strobes (master side)
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           CLK_50,
  input  logic           RST_N,
  input  logic           PS2_CLK,
  input  logic           PS2_DATA,
  ps2_receiver_if.master out_if
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e          state_q;
  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            filt_q;
  logic            filt_prev_q;
  logic [FW-1:0]   fcnt_q;
  logic [TW-1:0]   tcnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            ok_q;
  logic [7:0]      now_data_q;
  logic            ready_q;
  logic            parity_err_q;
  logic            frame_err_q;

  logic            fall_c;
  logic            bit_c;

  // One-cycle falling-edge indication of the filtered PS/2 clock.
  assign fall_c = filt_prev_q & ~filt_q;
  assign bit_c  = data_sync_q[1];

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      filt_prev_q  <= 1'b1;
      fcnt_q       <= '0;
      tcnt_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ok_q         <= 1'b0;
      now_data_q   <= '0;
      ready_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], PS2_CLK};
      data_sync_q  <= {data_sync_q[0], PS2_DATA};
      filt_prev_q  <= filt_q;
      ready_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // Glitch filter: follow the synchronized clock only after it has
      // disagreed for FILTER_LEN consecutive cycles.
      if (clk_sync_q[1] != filt_q) begin
        if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= clk_sync_q[1];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end else begin
        fcnt_q <= '0;
      end

      // Frame FSM; a falling edge takes priority over a timeout in the same cycle.
      if (fall_c) begin
        tcnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!bit_c) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {bit_c, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            ok_q    <= ^{shift_q, bit_c};
            state_q <= STOP;
          end
          STOP: begin
            if (!bit_c) begin
              frame_err_q <= 1'b1;
            end else if (ok_q) begin
              now_data_q <= shift_q;
              ready_q    <= 1'b1;
            end else begin
              parity_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        // Terminal count lands the abort TIMEOUT_CYCLES+1 cycles after the last fall.
        if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= IDLE;
          tcnt_q      <= '0;
          frame_err_q <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end else begin
        tcnt_q <= '0;
      end
    end
  end

  assign out_if.now_data   = now_data_q;
  assign out_if.ready      = ready_q;
  assign out_if.parity_err = parity_err_q;
  assign out_if.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of frames plus hand-written
// timeout, glitch and mid-frame reset sequences.
module tb_ps2_receiver;

  localparam int unsigned F    = 4;
  localparam int unsigned TO   = 200;
  localparam int          HALF = 20;

  logic CLK_50   = 1'b0;
  logic RST_N    = 1'b0;
  logic PS2_CLK  = 1'b1;
  logic PS2_DATA = 1'b1;

  ps2_receiver_if rx_if ();

  ps2_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_50  (CLK_50),
    .RST_N   (RST_N),
    .PS2_CLK (PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .out_if  (rx_if.master)
  );

  always #10 CLK_50 = ~CLK_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ready = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
  int last_flag_cyc = 0, last_fall_cyc = 0;
  logic [7:0] ready_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    bit         par_bad;
    bit         stop;
    bit         exp_ready;
    bit         exp_perr;
    bit         exp_ferr;
    logic [7:0] exp_now;
  } vec_t;

  vec_t vecs[9];

  initial forever begin
    @(posedge CLK_50);
    cyc++;
  end

  // Pulse monitor: counts strobes, flags overlap or a ready held two cycles.
  initial begin
    bit ready_prev = 1'b0;
    forever begin
      @(negedge CLK_50);
      if (RST_N) begin
        if (rx_if.ready) begin n_ready++; last_flag_cyc = cyc; ready_data = rx_if.now_data; end
        if (rx_if.parity_err) begin n_perr++; last_flag_cyc = cyc; end
        if (rx_if.frame_err) begin n_ferr++; last_flag_cyc = cyc; end
        if (32'(rx_if.ready) + 32'(rx_if.parity_err) + 32'(rx_if.frame_err) > 1) n_overlap++;
        if (rx_if.ready && ready_prev) n_overlap++;
        ready_prev = rx_if.ready;
      end else begin
        ready_prev = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input bit par_bad, input bit stop);
    return {stop, (~^d) ^ par_bad, d, 1'b0};
  endfunction

  // Sends the first n bits of a frame, LSB first, data set while clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      repeat (HALF) @(posedge CLK_50);
      #1;
      PS2_CLK = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge CLK_50);
      #1;
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " now_data"},   int'(rx_if.now_data),   0);
    check({tag, " ready"},      int'(rx_if.ready),      0);
    check({tag, " parity_err"}, int'(rx_if.parity_err), 0);
    check({tag, " frame_err"},  int'(rx_if.frame_err),  0);
  endtask

  initial begin
    int r0, p0, f0;

    //            data   pbad stop  rdy  perr ferr now
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[4] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[5] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[6] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

    repeat (5) @(posedge CLK_50);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    repeat (5) @(posedge CLK_50);
    #1;

    // Table frames, sent back to back.
    for (int i = 0; i < 9; i++) begin
      r0 = n_ready; p0 = n_perr; f0 = n_ferr;
      send_bits(frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop), 11);
      check($sformatf("vec%0d ready", i),      n_ready - r0, int'(vecs[i].exp_ready));
      check($sformatf("vec%0d parity_err", i), n_perr - p0,  int'(vecs[i].exp_perr));
      check($sformatf("vec%0d frame_err", i),  n_ferr - f0,  int'(vecs[i].exp_ferr));
      check($sformatf("vec%0d now_data", i),   int'(rx_if.now_data), int'(vecs[i].exp_now));
      check($sformatf("vec%0d latency", i),    last_flag_cyc - last_fall_cyc, int'(F) + 3);
      if (vecs[i].exp_ready)
        check($sformatf("vec%0d data_at_ready", i), int'(ready_data), int'(vecs[i].exp_now));
    end

    // Timeout: start + 5 data bits, then the clock stays high.
    r0 = n_ready; f0 = n_ferr;
    send_bits(frame(8'h3B, 1'b0, 1'b1), 6);
    repeat (TO + F + 60) @(posedge CLK_50);
    #1;
    check("timeout frame_err count", n_ferr - f0, 1);
    check("timeout ready count",     n_ready - r0, 0);
    check("timeout latency",         last_flag_cyc - last_fall_cyc, int'(F + TO) + 3);
    check("timeout now_data held",   int'(rx_if.now_data), 8'hFF);
    send_bits(frame(8'h5A, 1'b0, 1'b1), 11);
    check("post-timeout ready",      n_ready - r0, 1);
    check("post-timeout now_data",   int'(rx_if.now_data), 8'h5A);

    // Glitch in IDLE with data low: must not start a frame.
    r0 = n_ready; p0 = n_perr; f0 = n_ferr;
    PS2_DATA = 1'b0;
    @(posedge CLK_50);
    #1;
    PS2_CLK = 1'b0;
    repeat (F - 1) @(posedge CLK_50);
    #1;
    PS2_CLK = 1'b1;
    repeat (TO + 40) @(posedge CLK_50);
    #1;
    PS2_DATA = 1'b1;
    check("glitch no pulses", (n_ready - r0) + (n_perr - p0) + (n_ferr - f0), 0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    check("after glitch ready",    n_ready - r0, 1);
    check("after glitch errors",   (n_perr - p0) + (n_ferr - f0), 0);
    check("after glitch now_data", int'(rx_if.now_data), 8'h1C);

    // Reset mid-frame, then a clean frame.
    send_bits(frame(8'h77, 1'b0, 1'b1), 4);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK_50);
    #1;
    check_reset_outputs("midframe reset");
    RST_N = 1'b1;
    r0 = n_ready; p0 = n_perr; f0 = n_ferr;
    repeat (TO + 40) @(posedge CLK_50);
    #1;
    check("after reset no pulses", (n_ready - r0) + (n_perr - p0) + (n_ferr - f0), 0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    check("after reset ready",    n_ready - r0, 1);
    check("after reset now_data", int'(rx_if.now_data), 8'h1C);
    check("after reset latency",  last_flag_cyc - last_fall_cyc, int'(F) + 3);

    check("strobe overlap or double ready", n_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
